// File: rtl/regf_access_ctrl.sv
// regf_access_ctrl: zero-fills the register file after reset, then arbitrates its write port and read port-0 between core and debug
module regf_access_ctrl #(
   parameter int XLEN    = 32,
   parameter bit INIT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            areset,
   input  logic            i_core_halted,
   input  logic            i_wbu_wren,
   input  logic [4:0]      i_wbu_addr,
   input  logic [XLEN-1:0] i_wbu_data,
   input  logic            i_core_rden,
   input  logic [4:0]      i_core_rs0_addr,
   output logic            o_rf_wren,
   output logic [4:0]      o_rf_waddr,
   output logic [XLEN-1:0] o_rf_wdata,
   output logic            o_rf_rden,
   output logic [4:0]      o_rf_rs0_addr,
   input  logic [XLEN-1:0] i_rf_rs0_data,
   input  logic            i_dbg_req,
   input  logic            i_dbg_we,
   input  logic [4:0]      i_dbg_addr,
   input  logic [XLEN-1:0] i_dbg_wdata,
   output logic            o_dbg_ack,
   output logic [XLEN-1:0] o_dbg_rdata,
   output logic            o_init_busy
);
   typedef enum logic [1:0] {INIT, RUN, DRD, ACK} state_t;
   state_t     state, state_nxt;
   logic [4:0] cnt;
   logic       dbg_wr_gnt, dbg_rd_gnt;
   // debug is served only from RUN, while halted, and only when the core leaves the port idle
   assign dbg_wr_gnt  = state == RUN && i_dbg_req && i_dbg_we && i_core_halted && !i_wbu_wren;
   assign dbg_rd_gnt  = state == RUN && i_dbg_req && !i_dbg_we && i_core_halted && !i_wbu_wren && !i_core_rden;
   assign o_init_busy = state == INIT;
   // state, zero-fill counter and debug response registers
   always_ff @(posedge clk or posedge areset)
      if (areset) begin
         state       <= INIT_EN ? INIT : RUN;
         cnt         <= 5'd1;
         o_dbg_ack   <= 1'b0;
         o_dbg_rdata <= '0;
      end else begin
         state     <= state_nxt;
         o_dbg_ack <= state_nxt == ACK;
         if (state == INIT) cnt <= cnt + 5'd1;
         if (state == DRD) o_dbg_rdata <= i_rf_rs0_data;
      end
   // port muxing and next state; zero-fill owns the write port, core beats debug elsewhere
   always_comb begin
      o_rf_wren     = state == INIT || i_wbu_wren || (dbg_wr_gnt && |i_dbg_addr);
      o_rf_waddr    = state == INIT ? cnt : (i_wbu_wren ? i_wbu_addr : (dbg_wr_gnt ? i_dbg_addr : i_wbu_addr));
      o_rf_wdata    = state == INIT ? '0 : (i_wbu_wren ? i_wbu_data : (dbg_wr_gnt ? i_dbg_wdata : i_wbu_data));
      o_rf_rden     = i_core_rden || dbg_rd_gnt;
      o_rf_rs0_addr = dbg_rd_gnt ? i_dbg_addr : i_core_rs0_addr;
      state_nxt     = state == INIT ? (cnt == 5'd31 ? RUN : INIT) :
                      state == DRD  ? ACK :
                      state == ACK  ? RUN :
                      dbg_wr_gnt    ? ACK :
                      dbg_rd_gnt    ? DRD : RUN;
   end
endmodule

// File: tb/tb_regf_access_ctrl.sv
// tb_regf_access_ctrl: randomized self-checking bench with a register-file model and an architectural reference
module tb_regf_access_ctrl;
   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic        i_core_halted = 1'b1;
   logic        i_wbu_wren = 1'b0;
   logic [4:0]  i_wbu_addr = '0;
   logic [31:0] i_wbu_data = '0;
   logic        i_core_rden = 1'b0;
   logic [4:0]  i_core_rs0_addr = '0;
   logic        o_rf_wren;
   logic [4:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;
   logic        o_rf_rden;
   logic [4:0]  o_rf_rs0_addr;
   logic [31:0] rf_rd;
   logic        i_dbg_req = 1'b0;
   logic        i_dbg_we = 1'b0;
   logic [4:0]  i_dbg_addr = '0;
   logic [31:0] i_dbg_wdata = '0;
   logic        o_dbg_ack;
   logic [31:0] o_dbg_rdata;
   logic        o_init_busy;
   logic        scramble = 1'b1;
   logic [31:0] rf_mem [32];
   logic [31:0] ref_rf [32];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        r_we;
   logic [4:0]  r_addr;
   logic [31:0] r_data, r_exp;
   logic        granted, done;
   int          ack_at, acks, wrens;

   regf_access_ctrl dut (
      .clk(clk), .areset(areset), .i_core_halted(i_core_halted),
      .i_wbu_wren(i_wbu_wren), .i_wbu_addr(i_wbu_addr), .i_wbu_data(i_wbu_data),
      .i_core_rden(i_core_rden), .i_core_rs0_addr(i_core_rs0_addr),
      .o_rf_wren(o_rf_wren), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_rf_rden(o_rf_rden), .o_rf_rs0_addr(o_rf_rs0_addr), .i_rf_rs0_data(rf_rd),
      .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
      .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata), .o_init_busy(o_init_busy)
   );

   always #5 clk = ~clk;

   // register file: unreset array with garbage at start, x0 reads as zero, synchronous read
   always @(posedge clk)
      if (scramble) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= $urandom;
      end else begin
         if (o_rf_wren) rf_mem[o_rf_waddr] <= o_rf_wdata;
         if (o_rf_rden) rf_rd <= o_rf_rs0_addr == 5'd0 ? 32'd0 : rf_mem[o_rf_rs0_addr];
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic fill_check();
      areset = 1'b0;
      #1;
      for (int k = 1; k < 32; k++) begin
         chk("fill_ctl", 32'({o_init_busy, o_rf_wren, o_rf_waddr, o_dbg_ack}), 32'({2'b11, 5'(k), 1'b0}));
         chk("fill_data", o_rf_wdata, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      chk("fill_done_busy", 32'(o_init_busy), 32'd0);
      chk("fill_done_wren", 32'(o_rf_wren), 32'd0);
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
   endtask

   task automatic start_dbg(input logic we, input logic [4:0] a, input logic [31:0] d);
      i_dbg_req = 1'b1;
      i_dbg_we = we;
      i_dbg_addr = a;
      i_dbg_wdata = d;
      #1;
   endtask

   task automatic wait_ack(input string tag, input int exp_lat);
      int n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!o_dbg_ack && n < 50);
      chk(tag, 32'(n), 32'(exp_lat));
      i_dbg_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      start_dbg(1'b1, a, d);
      chk("dw_wren", 32'(o_rf_wren), 32'(a != 5'd0));
      wait_ack("dw_lat", 1);
      if (a != 5'd0) ref_rf[a] = d;
   endtask

   task automatic dbg_read(input logic [4:0] a);
      start_dbg(1'b0, a, 32'd0);
      chk("dr_port", 32'({o_rf_rden, o_rf_rs0_addr}), 32'({1'b1, a}));
      wait_ack("dr_lat", 2);
      chk("dr_data", o_dbg_rdata, ref_rf[a]);
   endtask

   initial begin
      #2 areset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      scramble = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", 32'({o_init_busy, o_rf_wren, o_rf_waddr, o_dbg_ack}), 32'({2'b11, 5'd1, 1'b0}));
      chk("rst_wdata", o_rf_wdata, 32'd0);
      chk("rst_rdata", o_dbg_rdata, 32'd0);
      fill_check();
      for (int a = 0; a < 32; a++) dbg_read(5'(a));
      dbg_write(5'd5, 32'hDEADBEEF);
      dbg_read(5'd5);
      i_wbu_wren = 1'b1;
      i_wbu_addr = 5'd7;
      i_wbu_data = 32'h22;
      start_dbg(1'b1, 5'd7, 32'h11);
      chk("cont_wbu", 32'({o_rf_wren, o_rf_waddr}), 32'({1'b1, 5'd7}));
      chk("cont_wbu_data", o_rf_wdata, 32'h22);
      @(posedge clk);
      @(negedge clk);
      i_wbu_wren = 1'b0;
      #1;
      chk("cont_no_ack", 32'(o_dbg_ack), 32'd0);
      chk("cont_dbg_data", o_rf_wdata, 32'h11);
      wait_ack("cont_lat", 1);
      ref_rf[7] = 32'h11;
      dbg_read(5'd7);
      i_core_halted = 1'b0;
      start_dbg(1'b1, 5'd3, 32'h1234);
      acks = 0;
      wrens = 0;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         acks += int'(o_dbg_ack);
         wrens += int'(o_rf_wren);
      end
      chk("nohalt_acks", 32'(acks), 32'd0);
      chk("nohalt_wrens", 32'(wrens), 32'd0);
      i_core_halted = 1'b1;
      #1;
      chk("halt_gnt", 32'(o_rf_wren), 32'd1);
      wait_ack("halt_lat", 1);
      ref_rf[3] = 32'h1234;
      dbg_write(5'd0, 32'hFFFFFFFF);
      dbg_read(5'd0);
      for (int it = 0; it < 150; it++) begin
         r_we = 1'($urandom_range(0, 1));
         r_addr = 5'($urandom_range(0, 31));
         r_data = $urandom;
         r_exp = '0;
         granted = 1'b0;
         done = 1'b0;
         ack_at = -1;
         start_dbg(r_we, r_addr, r_data);
         for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) begin
               chk("rnd_ack", 32'(o_dbg_ack), 32'(c == ack_at));
               if (c == ack_at) begin
                  if (!r_we) chk("rnd_rdata", o_dbg_rdata, r_exp);
                  done = 1'b1;
               end
            end
            if (!done) begin
               i_wbu_wren = $urandom_range(0, 2) == 0;
               i_wbu_addr = 5'($urandom_range(1, 31));
               i_wbu_data = $urandom;
               i_core_rden = $urandom_range(0, 3) == 0;
               i_core_rs0_addr = 5'($urandom_range(0, 31));
               i_core_halted = $urandom_range(0, 3) != 0;
               if (!granted && i_core_halted && !i_wbu_wren && (r_we || !i_core_rden)) begin
                  granted = 1'b1;
                  ack_at = c + (r_we ? 1 : 2);
                  if (r_we && r_addr != 5'd0) ref_rf[r_addr] = r_data;
                  if (!r_we) r_exp = ref_rf[r_addr];
               end
               if (i_wbu_wren) ref_rf[i_wbu_addr] = i_wbu_data;
               @(posedge clk);
               @(negedge clk);
            end
         end
         if (!done) chk("rnd_timeout", 32'd0, 32'd1);
         i_dbg_req = 1'b0;
         i_wbu_wren = 1'b0;
         i_core_rden = 1'b0;
         i_core_halted = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      for (int a = 0; a < 32; a++) dbg_read(5'(a));
      dbg_write(5'd9, 32'hA5A5A5A5);
      dbg_read(5'd9);
      start_dbg(1'b0, 5'd9, 32'd0);
      @(posedge clk);
      @(negedge clk);
      areset = 1'b1;
      #1;
      chk("drd_rst_ctl", 32'({o_init_busy, o_rf_wren, o_rf_waddr, o_dbg_ack}), 32'({2'b11, 5'd1, 1'b0}));
      chk("drd_rst_rdata", o_dbg_rdata, 32'd0);
      i_dbg_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("drd_rst_hold_ack", 32'(o_dbg_ack), 32'd0);
      fill_check();
      dbg_read(5'd9);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regf_access_ctrl.md
# regf_access_ctrl

Controller sitting between the core pipeline and the PQR5 register file (two synchronous read ports, one synchronous write port, no reset on the array). After reset it sequences a zero-fill of x1..x31 through the write port, because the array cannot be reset. It then shares the write port and read port-0 between the core (WBU write-back, decode reads) and a debug requester. Core traffic always has priority; debug accesses are granted only while the core is halted.

## Interface
- XLEN, 32, register width
- INIT_EN, 1, 1: run zero-fill after reset; 0: enter RUN directly from reset

- clk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- i_core_halted  in  1  core is halted; debug grants are allowed only while high
- i_wbu_wren  in  1  WBU write enable (never targets x0)
- i_wbu_addr  in  5  WBU destination register
- i_wbu_data  in  XLEN  WBU write data
- i_core_rden  in  1  decode read enable
- i_core_rs0_addr  in  5  decode read address, port-0
- o_rf_wren  out  1  to regfile write enable
- o_rf_waddr  out  5  to regfile write address
- o_rf_wdata  out  XLEN  to regfile write data
- o_rf_rden  out  1  to regfile read enable
- o_rf_rs0_addr  out  5  to regfile read address, port-0
- i_rf_rs0_data  in  XLEN  regfile port-0 read data (valid 1 cycle after rden)
- i_dbg_req  in  1  debug request; held until o_dbg_ack
- i_dbg_we  in  1  1 = write, 0 = read
- i_dbg_addr  in  5  debug register address
- i_dbg_wdata  in  XLEN  debug write data
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_rdata  out  XLEN  debug read data, valid with o_dbg_ack
- o_init_busy  out  1  zero-fill in progress; the core must stall

## Operation
- FSM states: INIT, RUN, DRD (debug read data pending), ACK.
- Reset puts the FSM in INIT when INIT_EN=1, or in RUN when INIT_EN=0.
  - Registered reset values: init counter = 1, o_dbg_ack = 0, o_dbg_rdata = 0.
- INIT:
  - Drives o_rf_wren = 1, o_rf_waddr = counter, o_rf_wdata = 0.
  - The counter increments every cycle. After the cycle that writes x31, the FSM goes to RUN.
  - o_init_busy = 1 only in INIT.
  - WBU writes are dropped. Debug requests are not granted.
  - o_rf_rden and o_rf_rs0_addr pass the core inputs through.
- RUN, write-port mux (combinational), in priority order:
  - i_wbu_wren: WBU address and data go to the regfile.
  - Else, a debug write grant (i_dbg_req & i_dbg_we & i_core_halted): debug address and data go to the regfile, and the FSM goes to ACK.
    - A debug write to x0 is granted and acked, but o_rf_wren stays 0.
  - Else, o_rf_wren = 0.
- RUN, read-port mux (combinational):
  - i_core_rden: core address passes through.
  - Else, a debug read grant (i_dbg_req & ~i_dbg_we & i_core_halted & ~i_wbu_wren): o_rf_rden = 1, o_rf_rs0_addr = i_dbg_addr, and the FSM goes to DRD.
  - Else, o_rf_rden = 0.
- DRD: i_rf_rs0_data is captured into o_dbg_rdata, then the FSM goes to ACK.
  - Core requests are still honoured in this cycle; with the core halted none are expected.
- ACK: o_dbg_ack = 1 for exactly one cycle, then the FSM returns to RUN.
  - No debug grant is made in ACK.
  - If i_dbg_req is still high in the cycle after ACK, it is a new request.
- o_dbg_rdata holds its value until the next debug read completes. Debug writes do not change it.
- Reset asserted in any state: FSM to INIT (or RUN), o_dbg_ack drops immediately, and any in-flight debug access is abandoned without an ack.

## Timing
- Zero-fill: when reset deasserts before clock edge E1, edges E1..E31 write x1..x31. o_init_busy falls after E31; it is high for 31 cycles.
- While areset is high with INIT_EN=1, o_rf_wren = 1, o_rf_waddr = 1, o_rf_wdata = 0 (repeated, harmless write of zero).
- Debug write: grant in cycle T (regfile write at the end of T); o_dbg_ack in T+1.
- Debug read: grant in cycle T; regfile data valid in T+1 and captured at the end of T+1; o_dbg_ack and o_dbg_rdata valid in T+2.
- WBU write and debug write in the same cycle: WBU wins, and the debug request waits with no ack.
- Core rden and debug read in the same cycle: core wins.
- i_core_halted low: a debug request waits indefinitely; this is not an error.

## Test plan
- Reset, then release: 31 writes of 0 to addresses 1..31 in consecutive cycles, o_init_busy high for 31 cycles. Debug reads of all registers then return 0.
- Halted, debug write x5 = 0xDEADBEEF, then debug read x5: write ack 1 cycle after grant; read ack 2 cycles after grant with o_dbg_rdata = 0xDEADBEEF.
- Halted, debug write x7 = 0x11 in the same cycle as WBU write x7 = 0x22: regfile gets 0x22 first, then 0x11 one cycle later. Final debug read of x7 = 0x11.
- i_core_halted = 0 with i_dbg_req high for 20 cycles: no grant, no ack. Raising halted: grant next cycle.
- Debug write x0 = 0xFFFFFFFF: ack received, o_rf_wren stays 0. Debug read x0 returns 0.
- areset pulsed during DRD: no ack, state INIT, zero-fill restarts from x1, o_dbg_rdata = 0.
